fetch_controller: RTL
=====================

# fetch_controller

Sequences the combinational, word-addressed instruction memory for the vectorized CPU pipeline. Owns the PC register, drives the memory address, and loads the fetched word into the IF/ID pipeline register. Handles stall from the hazard unit, branch redirect/flush from execute, halt-instruction detection and out-of-range PC faults. Sits between the instruction memory and the decode stage.

## Interface
- PC_WIDTH, 32, width of PC; PC is a word index, not a byte address
- INSTRUCTION_WIDTH, 32, instruction word width
- MEMORY_SIZE, 1024, number of instruction words; valid PC range 0..MEMORY_SIZE-1
- RESET_PC, 0, PC loaded on reset
- HALT_INSTRUCTION, all ones (INSTRUCTION_WIDTH bits), encoding that halts fetch

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; leaves IDLE
- stall  in  1  hold PC and IF/ID contents
- redirect_valid  in  1  taken branch/jump from execute; flushes IF/ID
- redirect_pc  in  PC_WIDTH  redirect target
- imem_pc  out  PC_WIDTH  address to instruction memory (equals PC register)
- imem_instruction  in  INSTRUCTION_WIDTH  memory read data, same cycle as imem_pc
- if_valid  out  1  IF/ID entry holds a real instruction
- if_instruction  out  INSTRUCTION_WIDTH  IF/ID instruction
- if_pc  out  PC_WIDTH  PC of if_instruction
- halted  out  1  state is HALTED
- fault  out  1  sticky; fetch attempted at PC >= MEMORY_SIZE

## Operation
- States: IDLE, RUN, HALTED.
- IDLE: PC held; start=1 moves to RUN. redirect_valid in IDLE loads PC and moves to RUN.
- RUN, no stall, no redirect, PC < MEMORY_SIZE: if_instruction <= imem_instruction, if_pc <= PC, if_valid <= 1, PC <= PC+1 (PC_WIDTH wrap, no saturation). If imem_instruction == HALT_INSTRUCTION it is still emitted valid, PC is not incremented, next state HALTED.
- RUN, PC >= MEMORY_SIZE (not stalled, no redirect): no latch, if_valid <= 0, fault <= 1, next state HALTED.
- stall=1 (no redirect): PC, state, all if_* outputs hold.
- redirect_valid=1 (any state, overrides stall): PC <= redirect_pc, if_valid <= 0 (if_instruction/if_pc hold), next state RUN. Resumes from HALTED (squashes speculative halt); fault not cleared.
- IDLE/HALTED, no stall, no redirect: if_valid <= 0.
- start outside IDLE ignored.
- Priority: reset > redirect_valid > stall > normal fetch/halt/fault.

## Timing
- Reset values: PC=RESET_PC, state IDLE, if_valid=0, if_instruction=0, if_pc=0, halted=0, fault=0. Reset mid-operation restores all on the next edge regardless of other inputs.
- imem_pc combinational from PC register; memory read combinational.
- Latency: start seen at edge N -> RUN after N; instruction at RESET_PC valid on if_* after edge N+1; one new instruction per unstalled cycle thereafter.
- Redirect at edge N -> bubble (if_valid=0) after N; target instruction valid after N+1. Exactly one bubble per redirect.
- Halt fetched at edge N -> halted=1 and halt word valid after N; if_valid=0 after N+1 unless stalled.
- Redirect and halt word in same cycle: redirect wins, halt word discarded, no HALTED.

## Structure
- Package fetch_pkg: fetch_state_t enum {IDLE, RUN, HALTED}; default HALT_INSTRUCTION constant.
- Sub-module fetch_decode_register: IF/ID register with load, hold (stall) and flush (clear valid) controls; controller contains FSM and PC logic.

## Test plan
- Reset then start, memory 0..3 = A,B,C,D: if_instruction A,B,C,D on consecutive cycles, if_pc 0,1,2,3, if_valid=1 from second cycle after start.
- stall=1 for 3 cycles while if_pc=1: if_pc/if_instruction/imem_pc frozen (1,B,2), resumes with C at if_pc=2.
- redirect_valid=1, redirect_pc=10 with stall=1 same cycle: one if_valid=0 bubble, then if_pc=10 with mem[10].
- mem[5]=HALT_INSTRUCTION: halt word emitted valid at if_pc=5, halted=1, imem_pc stays 5; redirect to 20 resumes with if_pc=20, halted=0.
- MEMORY_SIZE=8, straight-line code with no halt: after if_pc=7, fault=1, halted=1, if_valid=0; fault stays 1 after redirect to 0, cleared only by reset.
- Reset asserted mid-RUN with stall=1 and redirect_valid=1: all outputs at reset values next edge, state IDLE, no fetch until start.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Exports the fetch FSM state encoding and the default halt word.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int          DEFAULT_INSTRUCTION_WIDTH = 32;
    localparam logic [31:0] DEFAULT_HALT_INSTRUCTION  = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_decode_register.sv
// IF/ID pipeline register with load, hold and flush controls.
// Ports: clk, i_reset (sync, active-high), i_load, i_hold, i_flush,
//        i_instruction/i_pc (data in), o_valid/o_instruction/o_pc (data out).
module fetch_decode_register #(
    parameter int PC_WIDTH          = 32,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic                         i_load,
    input  logic                         i_hold,
    input  logic                         i_flush,
    input  logic [INSTRUCTION_WIDTH-1:0] i_instruction,
    input  logic [PC_WIDTH-1:0]          i_pc,
    output logic                         o_valid,
    output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
    output logic [PC_WIDTH-1:0]          o_pc
);

    logic                         r_valid;
    logic [INSTRUCTION_WIDTH-1:0] r_instruction;
    logic [PC_WIDTH-1:0]          r_pc;

    // Flush only clears valid; the payload is kept so a bubble still
    // shows the last fetched word and its PC.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_valid       <= 1'b0;
            r_instruction <= '0;
            r_pc          <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (!i_hold && i_load) begin
            r_valid       <= 1'b1;
            r_instruction <= i_instruction;
            r_pc          <= i_pc;
        end
    end

    assign o_valid       = r_valid;
    assign o_instruction = r_instruction;
    assign o_pc          = r_pc;

endmodule

// File: rtl/fetch_controller.sv
// Fetch controller: owns the PC, drives the instruction memory address,
// and fills the IF/ID register. Handles stall, redirect, halt and faults.
// Ports: clk, reset, start, stall, redirect_valid/redirect_pc in;
//        imem_pc out, imem_instruction in; if_valid/if_instruction/if_pc,
//        halted, fault out.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                           PC_WIDTH          = 32,
    parameter int                           INSTRUCTION_WIDTH = 32,
    parameter int                           MEMORY_SIZE       = 1024,
    parameter logic [PC_WIDTH-1:0]          RESET_PC          = '0,
    parameter logic [INSTRUCTION_WIDTH-1:0] HALT_INSTRUCTION  = '1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stall,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH-1:0]          redirect_pc,
    output logic [PC_WIDTH-1:0]          imem_pc,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_instruction,
    output logic                         if_valid,
    output logic [INSTRUCTION_WIDTH-1:0] if_instruction,
    output logic [PC_WIDTH-1:0]          if_pc,
    output logic                         halted,
    output logic                         fault
);

    // One extra bit so MEMORY_SIZE == 2**PC_WIDTH still compares correctly.
    localparam logic [PC_WIDTH:0] MEM_LIMIT = (PC_WIDTH+1)'(MEMORY_SIZE);

    fetch_state_t        r_state;
    fetch_state_t        w_next_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_next_pc;
    logic                r_fault;
    logic                w_next_fault;
    logic                w_load;
    logic                w_flush;
    logic                w_hold;
    logic                w_pc_in_range;
    logic                w_is_halt;

    assign w_pc_in_range = ({1'b0, r_pc} < MEM_LIMIT);
    assign w_is_halt     = (imem_instruction == HALT_INSTRUCTION);
    assign w_hold        = stall && !redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            r_fault <= w_next_fault;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_fault = r_fault;
        w_load       = 1'b0;
        w_flush      = 1'b0;
        if (redirect_valid) begin
            // Redirect beats stall and discards whatever is being fetched,
            // including a halt word, so no HALTED transition happens here.
            w_next_pc    = redirect_pc;
            w_next_state = RUN;
            w_flush      = 1'b1;
        end else if (!stall) begin
            unique case (r_state)
                IDLE: begin
                    w_flush = 1'b1;
                    if (start) begin
                        w_next_state = RUN;
                    end
                end
                RUN: begin
                    if (!w_pc_in_range) begin
                        w_flush      = 1'b1;
                        w_next_fault = 1'b1;
                        w_next_state = HALTED;
                    end else begin
                        w_load = 1'b1;
                        if (w_is_halt) begin
                            // PC parks on the halt word.
                            w_next_state = HALTED;
                        end else begin
                            w_next_pc = r_pc + PC_WIDTH'(1);
                        end
                    end
                end
                HALTED: begin
                    w_flush = 1'b1;
                end
                default: begin
                    w_flush      = 1'b1;
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    fetch_decode_register #(
        .PC_WIDTH          (PC_WIDTH),
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH)
    ) u_if_id (
        .clk           (clk),
        .i_reset       (reset),
        .i_load        (w_load),
        .i_hold        (w_hold),
        .i_flush       (w_flush),
        .i_instruction (imem_instruction),
        .i_pc          (r_pc),
        .o_valid       (if_valid),
        .o_instruction (if_instruction),
        .o_pc          (if_pc)
    );

    assign imem_pc = r_pc;
    assign halted  = (r_state == HALTED);
    assign fault   = r_fault;

endmodule
